video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_timing_pkg.sv | 37 +++
 rtl/video_timing_if.sv | 49 ++++
 rtl/timing_axis.sv | 98 +++++++++
 rtl/video_timing.sv | 161 ++++++++++++++++
 tb/tb_video_timing.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the video timing generator: counter width, standard
// mode timings and the sync polarity encoding.
package video_timing_pkg;

  localparam int CNT_W_DEF = 11;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  // 640x480 @ 60 Hz
  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_V_VIS  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  // 800x600 @ 60 Hz
  localparam int unsigned SVGA_H_VIS  = 800;
  localparam int unsigned SVGA_H_FP   = 40;
  localparam int unsigned SVGA_H_SYNC = 128;
  localparam int unsigned SVGA_H_BP   = 88;
  localparam int unsigned SVGA_V_VIS  = 600;
  localparam int unsigned SVGA_V_FP   = 1;
  localparam int unsigned SVGA_V_SYNC = 4;
  localparam int unsigned SVGA_V_BP   = 23;

  // Drives the sync pin to its active level when asserted, else inactive.
  function automatic logic sync_level(input logic pol, input logic assert_sync);
    return assert_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Configuration and timing-output bundle of the video timing generator.
interface video_timing_if #(
  parameter int CNT_W = video_timing_pkg::CNT_W_DEF
) ();
  import video_timing_pkg::*;

  logic             ce;
  logic             cfg_load;
  logic [CNT_W-1:0] cfg_h_vis;
  logic [CNT_W-1:0] cfg_h_fp;
  logic [CNT_W-1:0] cfg_h_sync;
  logic [CNT_W-1:0] cfg_h_bp;
  logic [CNT_W-1:0] cfg_v_vis;
  logic [CNT_W-1:0] cfg_v_fp;
  logic [CNT_W-1:0] cfg_v_sync;
  logic [CNT_W-1:0] cfg_v_bp;
  logic             cfg_hs_pol;
  logic             cfg_vs_pol;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_sync;
  logic             v_sync;
  logic             blank;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic             cfg_pending;
  logic             cfg_err;

  modport master (
    output ce, cfg_load,
    output cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    output cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_hs_pol, cfg_vs_pol,
    input  h_cnt, v_cnt, h_sync, v_sync, blank, active,
    input  line_start, frame_start, cfg_pending, cfg_err
  );

  modport slave (
    input  ce, cfg_load,
    input  cfg_h_vis, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    input  cfg_v_vis, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_hs_pol, cfg_vs_pol,
    output h_cnt, v_cnt, h_sync, v_sync, blank, active,
    output line_start, frame_start, cfg_pending, cfg_err
  );

endinterface

// File: rtl/timing_axis.sv
// One timing axis: position counter, active timing registers and the
// registered sync decode, all computed from the next position so they align.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int          CNT_W = CNT_W_DEF,
  parameter int unsigned VIS   = VGA_H_VIS,
  parameter int unsigned FP    = VGA_H_FP,
  parameter int unsigned SYNC  = VGA_H_SYNC,
  parameter int unsigned BP    = VGA_H_BP,
  parameter bit          POL   = POL_LOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             swap,
  input  logic [CNT_W-1:0] new_vis,
  input  logic [CNT_W-1:0] new_fp,
  input  logic [CNT_W-1:0] new_sync,
  input  logic [CNT_W-1:0] new_bp,
  input  logic             new_pol,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             last,
  output logic             blank_nxt,
  output logic             zero_nxt
);

  localparam int SW = CNT_W + 2;

  logic [CNT_W-1:0] cnt_reg;
  logic             sync_reg;
  logic [CNT_W-1:0] vis_reg;
  logic [CNT_W-1:0] fp_reg;
  logic [CNT_W-1:0] sync_len_reg;
  logic [CNT_W-1:0] bp_reg;
  logic             pol_reg;

  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] vis_next;
  logic [CNT_W-1:0] fp_next;
  logic [CNT_W-1:0] sync_len_next;
  logic             pol_next;
  logic [SW-1:0]    tot_cur;
  logic [SW-1:0]    sync_start;
  logic [SW-1:0]    sync_end;
  logic             sync_on;

  assign tot_cur = SW'(vis_reg) + SW'(fp_reg) + SW'(sync_len_reg) + SW'(bp_reg);
  assign last    = (SW'(cnt_reg) == (tot_cur - SW'(1)));

  // A swap only happens on the frame-end edge, so the counter restarts
  // and the first pixel is decoded against the incoming timing.
  always_comb begin
    vis_next      = swap ? new_vis  : vis_reg;
    fp_next       = swap ? new_fp   : fp_reg;
    sync_len_next = swap ? new_sync : sync_len_reg;
    pol_next      = swap ? new_pol  : pol_reg;
    if (swap) begin
      cnt_next = '0;
    end else if (step) begin
      cnt_next = last ? '0 : cnt_reg + CNT_W'(1);
    end else begin
      cnt_next = cnt_reg;
    end
    sync_start = SW'(vis_next) + SW'(fp_next);
    sync_end   = sync_start + SW'(sync_len_next);
    sync_on    = (SW'(cnt_next) >= sync_start) && (SW'(cnt_next) < sync_end);
    blank_nxt  = (cnt_next >= vis_next);
    zero_nxt   = (cnt_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      sync_reg     <= ~POL;
      vis_reg      <= CNT_W'(VIS);
      fp_reg       <= CNT_W'(FP);
      sync_len_reg <= CNT_W'(SYNC);
      bp_reg       <= CNT_W'(BP);
      pol_reg      <= POL;
    end else begin
      cnt_reg  <= cnt_next;
      sync_reg <= sync_level(pol_next, sync_on);
      if (swap) begin
        vis_reg      <= new_vis;
        fp_reg       <= new_fp;
        sync_len_reg <= new_sync;
        bp_reg       <= new_bp;
        pol_reg      <= new_pol;
      end
    end
  end

  assign cnt  = cnt_reg;
  assign sync = sync_reg;

endmodule

// File: rtl/video_timing.sv
// Programmable raster timing generator with a shadowed configuration that
// is swapped in atomically at the end of a frame.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int          CNT_W  = CNT_W_DEF,
  parameter int unsigned H_VIS  = VGA_H_VIS,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_VIS  = VGA_V_VIS,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP,
  parameter bit          HS_POL = POL_LOW,
  parameter bit          VS_POL = POL_LOW
) (
  input  logic          clk,
  input  logic          rst,
  video_timing_if.slave bus
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] TOT_MAX = SW'((64'd1 << CNT_W) - 64'd1);
  localparam int unsigned FIELD_RST [8] = '{H_VIS, H_FP, H_SYNC, H_BP,
                                             V_VIS, V_FP, V_SYNC, V_BP};

  logic [CNT_W-1:0] cfg_field [8];
  logic [7:0]       field_nz;
  logic [SW-1:0]    h_tot_in;
  logic [SW-1:0]    v_tot_in;
  logic             load_ok;

  logic [CNT_W-1:0] shadow_reg [8];
  logic             sh_hs_pol_reg;
  logic             sh_vs_pol_reg;
  logic             pending_reg;
  logic             err_reg;
  logic             blank_reg;
  logic             active_reg;
  logic             line_start_reg;
  logic             frame_start_reg;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_sync;
  logic             v_sync;
  logic             h_last;
  logic             v_last;
  logic             h_blank_nxt;
  logic             v_blank_nxt;
  logic             h_zero_nxt;
  logic             v_zero_nxt;
  logic             frame_end;
  logic             apply;

  assign cfg_field[0] = bus.cfg_h_vis;
  assign cfg_field[1] = bus.cfg_h_fp;
  assign cfg_field[2] = bus.cfg_h_sync;
  assign cfg_field[3] = bus.cfg_h_bp;
  assign cfg_field[4] = bus.cfg_v_vis;
  assign cfg_field[5] = bus.cfg_v_fp;
  assign cfg_field[6] = bus.cfg_v_sync;
  assign cfg_field[7] = bus.cfg_v_bp;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nz
      assign field_nz[gi] = |cfg_field[gi];
    end
  endgenerate

  // Totals are widened so an overflowing sum is seen rather than wrapped.
  assign h_tot_in = SW'(bus.cfg_h_vis) + SW'(bus.cfg_h_fp) + SW'(bus.cfg_h_sync) + SW'(bus.cfg_h_bp);
  assign v_tot_in = SW'(bus.cfg_v_vis) + SW'(bus.cfg_v_fp) + SW'(bus.cfg_v_sync) + SW'(bus.cfg_v_bp);
  assign load_ok  = bus.cfg_load && (&field_nz) && (h_tot_in <= TOT_MAX) && (v_tot_in <= TOT_MAX);

  assign frame_end = bus.ce && h_last && v_last;
  assign apply     = frame_end && pending_reg;

  timing_axis #(
    .CNT_W(CNT_W), .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_axis (
    .clk       (clk),
    .rst       (rst),
    .step      (bus.ce),
    .swap      (apply),
    .new_vis   (shadow_reg[0]),
    .new_fp    (shadow_reg[1]),
    .new_sync  (shadow_reg[2]),
    .new_bp    (shadow_reg[3]),
    .new_pol   (sh_hs_pol_reg),
    .cnt       (h_cnt),
    .sync      (h_sync),
    .last      (h_last),
    .blank_nxt (h_blank_nxt),
    .zero_nxt  (h_zero_nxt)
  );

  timing_axis #(
    .CNT_W(CNT_W), .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_axis (
    .clk       (clk),
    .rst       (rst),
    .step      (bus.ce && h_last),
    .swap      (apply),
    .new_vis   (shadow_reg[4]),
    .new_fp    (shadow_reg[5]),
    .new_sync  (shadow_reg[6]),
    .new_bp    (shadow_reg[7]),
    .new_pol   (sh_vs_pol_reg),
    .cnt       (v_cnt),
    .sync      (v_sync),
    .last      (v_last),
    .blank_nxt (v_blank_nxt),
    .zero_nxt  (v_zero_nxt)
  );

  // The apply uses the shadow as it stood before this edge, so a load
  // landing on the frame-end edge waits for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow_reg[i] <= CNT_W'(FIELD_RST[i]);
      end
      sh_hs_pol_reg   <= HS_POL;
      sh_vs_pol_reg   <= VS_POL;
      pending_reg     <= 1'b0;
      err_reg         <= 1'b0;
      blank_reg       <= 1'b0;
      active_reg      <= 1'b1;
      line_start_reg  <= 1'b1;
      frame_start_reg <= 1'b1;
    end else begin
      if (load_ok) begin
        for (int i = 0; i < 8; i++) begin
          shadow_reg[i] <= cfg_field[i];
        end
        sh_hs_pol_reg <= bus.cfg_hs_pol;
        sh_vs_pol_reg <= bus.cfg_vs_pol;
      end
      pending_reg     <= load_ok || (pending_reg && !apply);
      err_reg         <= bus.cfg_load && !load_ok;
      blank_reg       <= h_blank_nxt || v_blank_nxt;
      active_reg      <= !(h_blank_nxt || v_blank_nxt);
      line_start_reg  <= h_zero_nxt;
      frame_start_reg <= h_zero_nxt && v_zero_nxt;
    end
  end

  assign bus.h_cnt       = h_cnt;
  assign bus.v_cnt       = v_cnt;
  assign bus.h_sync      = h_sync;
  assign bus.v_sync      = v_sync;
  assign bus.blank       = blank_reg;
  assign bus.active      = active_reg;
  assign bus.line_start  = line_start_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.cfg_pending = pending_reg;
  assign bus.cfg_err     = err_reg;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing: per-pixel comparison against a
// position/config model plus directed line, frame and config-swap sequences.
module tb_video_timing;

  localparam int CW      = 11;
  localparam int TOT_MAX = (1 << CW) - 1;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
    bit hp, vp;
  } tcfg_t;

  typedef struct {
    tcfg_t c;
    bit    exp_err;
    bit    exp_pend;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  video_timing_if #(.CNT_W(CW)) vif ();

  video_timing #(
    .CNT_W(CW),
    .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  tcfg_t p_cfg, svga, small_cfg, drv;
  tcfg_t act, shd;
  int    mx, my;
  bit    m_pend, m_err;
  vec_t  tbl [6];

  // h, v, h_sync, v_sync, blank, active, line_start, frame_start, pending, err
  localparam logic [29:0] RESET_VEC = {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input longint got, input longint exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  function automatic int tot_h(input tcfg_t c);
    return c.hv + c.hf + c.hs + c.hb;
  endfunction

  function automatic int tot_v(input tcfg_t c);
    return c.vv + c.vf + c.vs + c.vb;
  endfunction

  function automatic bit cfg_ok(input tcfg_t c);
    return c.hv != 0 && c.hf != 0 && c.hs != 0 && c.hb != 0 &&
           c.vv != 0 && c.vf != 0 && c.vs != 0 && c.vb != 0 &&
           tot_h(c) <= TOT_MAX && tot_v(c) <= TOT_MAX;
  endfunction

  function automatic logic [29:0] model_vec();
    bit hs, vs, bl;
    hs = (mx >= act.hv + act.hf && mx < act.hv + act.hf + act.hs) ? act.hp : !act.hp;
    vs = (my >= act.vv + act.vf && my < act.vv + act.vf + act.vs) ? act.vp : !act.vp;
    bl = (mx >= act.hv) || (my >= act.vv);
    return {11'(mx), 11'(my), hs, vs, bl, !bl, (mx == 0), (mx == 0 && my == 0), m_pend, m_err};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {vif.h_cnt, vif.v_cnt, vif.h_sync, vif.v_sync, vif.blank, vif.active,
            vif.line_start, vif.frame_start, vif.cfg_pending, vif.cfg_err};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; act = p_cfg; shd = p_cfg; m_pend = 0; m_err = 0;
  endtask

  task automatic drive_cfg(input tcfg_t c);
    drv = c;
    vif.cfg_h_vis = 11'(c.hv); vif.cfg_h_fp = 11'(c.hf);
    vif.cfg_h_sync = 11'(c.hs); vif.cfg_h_bp = 11'(c.hb);
    vif.cfg_v_vis = 11'(c.vv); vif.cfg_v_fp = 11'(c.vf);
    vif.cfg_v_sync = 11'(c.vs); vif.cfg_v_bp = 11'(c.vb);
    vif.cfg_hs_pol = c.hp; vif.cfg_vs_pol = c.vp;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    bit ok, fe;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      ok = vif.cfg_load && cfg_ok(drv);
      fe = vif.ce && mx == tot_h(act) - 1 && my == tot_v(act) - 1;
      if (vif.ce) begin
        if (mx == tot_h(act) - 1) begin
          mx = 0;
          my = (my == tot_v(act) - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
      if (fe && m_pend) begin
        act = shd;
        m_pend = 0;
      end
      if (ok) begin
        shd = drv;
        m_pend = 1;
      end
      m_err = vif.cfg_load && !ok;
    end
    #1;
    check("pixel", dut_vec(), model_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_tick(input tcfg_t c);
    drive_cfg(c);
    vif.cfg_load = 1'b1;
    tick();
    vif.cfg_load = 1'b0;
  endtask

  function automatic int to_frame_end();
    return (tot_v(act) - 1 - my) * tot_h(act) + (tot_h(act) - 1 - mx);
  endfunction

  // Runs one line from h_cnt==0 and checks sync placement and line length.
  task automatic measure_line(input string nm, input int len, input int first,
                              input int width, input bit pol);
    int n_on, f;
    n_on = 0; f = -1;
    vif.ce = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (vif.h_sync == pol) begin
        if (f < 0) f = int'(vif.h_cnt);
        n_on++;
      end
      tick();
    end
    check({nm, "_sync_first"}, f, first);
    check({nm, "_sync_width"}, n_on, width);
    check({nm, "_wrap"}, {vif.h_cnt, vif.line_start}, {11'd0, 1'b1});
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", dut_vec(), RESET_VEC);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  function automatic int rnd_field();
    return ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 900));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int vs_lines, vs_first;
    tcfg_t r;
    p_cfg     = '{640, 16, 96, 48, 5, 1, 2, 2, 1'b0, 1'b0};
    svga      = '{800, 40, 128, 88, 5, 1, 2, 2, 1'b1, 1'b1};
    small_cfg = '{20, 2, 4, 2, 5, 1, 2, 2, 1'b0, 1'b1};
    tbl[0] = '{'{800, 40, 0, 88, 5, 1, 2, 2, 1'b1, 1'b1}, 1'b1, 1'b0};
    tbl[1] = '{'{640, 16, 96, 48, 5, 1, 2, 0, 1'b0, 1'b0}, 1'b1, 1'b0};
    tbl[2] = '{'{1024, 512, 256, 256, 5, 1, 2, 2, 1'b0, 1'b0}, 1'b1, 1'b0};
    tbl[3] = '{'{1000, 500, 300, 247, 5, 1, 2, 2, 1'b0, 1'b1}, 1'b0, 1'b1};
    tbl[4] = '{svga, 1'b0, 1'b1};
    tbl[5] = '{'{640, 16, 96, 48, 2000, 40, 5, 3, 1'b1, 1'b0}, 1'b1, 1'b1};

    vif.ce = 1'b0;
    vif.cfg_load = 1'b0;
    drive_cfg(p_cfg);
    rst = 1'b1;
    model_reset();
    #12;
    check("reset_state", dut_vec(), RESET_VEC);
    run(2);
    rst = 1'b0;

    // Free run: one measured line, then the rest of the frame line by line.
    measure_line("vga_line0", 800, 656, 96, 1'b0);
    check("vga_line1_v", vif.v_cnt, 1);
    vs_lines = 0; vs_first = -1;
    vif.ce = 1'b1;
    for (int l = 1; l < 10; l++) begin
      if (vif.v_sync == 1'b0) begin
        if (vs_first < 0) vs_first = int'(vif.v_cnt);
        vs_lines++;
      end
      run(800);
    end
    check("vsync_first_line", vs_first, 6);
    check("vsync_lines", vs_lines, 2);
    check("frame_wrap", {vif.frame_start, vif.v_cnt, vif.h_cnt}, {1'b1, 11'd0, 11'd0});

    // ce at half rate: line period doubles.
    for (int k = 1; k <= 1600; k++) begin
      vif.ce = (k % 2 == 0);
      tick();
      if (k == 1599) check("half_rate_last_px", {vif.h_cnt, vif.v_cnt}, {11'd799, 11'd0});
    end
    check("half_rate_wrap", {vif.h_cnt, vif.v_cnt}, {11'd0, 11'd1});

    // Random ce with occasional random config loads.
    for (int k = 0; k < 3000; k++) begin
      vif.ce = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        r = '{rnd_field(), rnd_field(), rnd_field(), rnd_field(),
              rnd_field(), rnd_field(), rnd_field(), rnd_field(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        load_tick(r);
      end else begin
        tick();
      end
    end
    do_reset();

    // Config acceptance table, applied with ce low.
    vif.ce = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_tick(tbl[i].c);
      check($sformatf("tbl%0d_err", i), vif.cfg_err, tbl[i].exp_err);
      check($sformatf("tbl%0d_pend", i), vif.cfg_pending, tbl[i].exp_pend);
      tick();
      check($sformatf("tbl%0d_err_clear", i), vif.cfg_err, 0);
    end

    // Pending config waits for the frame end, then 1056-wide active-high lines.
    vif.ce = 1'b1;
    run(to_frame_end());
    check("hold_pending", {vif.cfg_pending, vif.h_cnt, vif.v_cnt}, {1'b1, 11'd799, 11'd9});
    tick();
    check("apply_edge", {vif.cfg_pending, vif.h_cnt, vif.v_cnt, vif.h_sync, vif.v_sync},
          {1'b0, 11'd0, 11'd0, 1'b0, 1'b0});
    measure_line("svga_line0", 1056, 840, 128, 1'b1);

    // Load on the frame-end edge: applied one frame later.
    run(to_frame_end());
    load_tick(small_cfg);
    check("fe_load", {vif.cfg_pending, vif.h_cnt, vif.v_cnt}, {1'b1, 11'd0, 11'd0});
    measure_line("fe_old_line", 1056, 840, 128, 1'b1);
    run(to_frame_end());
    tick();
    check("fe_applied", {vif.cfg_pending, vif.h_cnt, vif.v_cnt}, {1'b0, 11'd0, 11'd0});
    measure_line("fe_new_line", 28, 22, 4, 1'b0);

    // Reset mid-frame with a config pending.
    run(2 * 28);
    check("pre_rst_v", vif.v_cnt, 3);
    load_tick(svga);
    run(5);
    check("pre_rst_pend", vif.cfg_pending, 1);
    do_reset();
    measure_line("post_rst_line", 800, 656, 96, 1'b0);
    check("post_rst_pend", vif.cfg_pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
